// File: rtl/sprite_ram_loader.sv
// Writable 64x64 sprite store: fills the RAM in raster order from a valid/ready pixel stream
// and serves palette indices to the color mapper with a one-cycle registered read.
module sprite_ram_loader #(
  parameter int unsigned PIX_W  = 3,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [18:0]       read_address,
  output logic [PIX_W-1:0]  sprite_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pix_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned RA_W  = 19;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, busy_q, done_q;
  logic [PIX_W-1:0]   sprite_q;
  logic               we_c;

  logic [PIX_W-1:0]   mem [DEPTH];

  // Abort outranks start; start outranks a same-cycle pixel, which is discarded.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_c    = 1'b0;
    if (load_abort) begin
      if (state_q != IDLE) state_d = IDLE;
    end else if (load_start) begin
      state_d = LOAD;
      ptr_d   = '0;
      count_d = '0;
    end else if (state_q == LOAD && pix_valid && ready_q) begin
      we_c  = 1'b1;
      ptr_d = ptr_q + ADDR_W'(1);
      if (count_q < CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
      if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
    end
  end

  // State, handshake/status outputs and the masked read register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sprite_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      ready_q  <= (state_d == LOAD);
      busy_q   <= (state_d == LOAD);
      done_q   <= (state_d == DONE);
      if (state_d == LOAD || read_address >= RA_W'(DEPTH))
        sprite_q <= '0;
      else
        sprite_q <= mem[read_address[ADDR_W-1:0]];
    end
  end

  // RAM write port; contents intentionally survive reset.
  always_ff @(posedge Clk) begin
    if (we_c) mem[ptr_q] <= pix_data;
  end

  assign pix_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pix_count  = count_q;
  assign sprite_out = sprite_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: loads, backpressure, abort, collisions, read masking, async reset.
module tb_sprite_ram_loader;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        load_start, load_abort;
  logic [2:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [18:0] read_address;
  logic [2:0]  sprite_out;
  logic        busy, done;
  logic [12:0] pix_count;

  int tests  = 0;
  int failed = 0;

  sprite_ram_loader dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .load_start   (load_start),
    .load_abort   (load_abort),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .read_address (read_address),
    .sprite_out   (sprite_out),
    .busy         (busy),
    .done         (done),
    .pix_count    (pix_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input logic [18:0] a, input logic [2:0] exp, input string tag);
    read_address = a;
    step();
    check(tag, 32'(sprite_out), 32'(exp));
  endtask

  initial begin
    int nbusy;
    int idx;
    int cyc;
    logic v;
    Reset_n = 1'b0; load_start = 1'b0; load_abort = 1'b0;
    pix_data = '0; pix_valid = 1'b0; read_address = '0;

    // Reset held for three cycles
    repeat (3) step();
    check("rst_ready", 32'(pix_ready), 0);
    Reset_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_count", 32'(pix_count), 0);
    check("idle_sprite", 32'(sprite_out), 0);
    check("idle_ready", 32'(pix_ready), 0);

    // Valid pixels in IDLE are ignored
    pix_valid = 1'b1;
    repeat (10) step();
    check("idle_valid_count", 32'(pix_count), 0);
    pix_valid = 1'b0;

    // Full load, pix_data = addr % 8, valid held high
    load_start = 1'b1; step(); load_start = 1'b0;
    check("load_busy", 32'(busy), 1);
    read_address = 19'd5;
    nbusy = 0;
    for (int i = 0; i < 4096; i++) begin
      pix_data = 3'(i % 8);
      pix_valid = 1'b1;
      if (busy) nbusy++;
      step();
      if (i == 10) check("load_mask_rd5", 32'(sprite_out), 0);
    end
    pix_valid = 1'b0;
    check("full_busy_beats", 32'(nbusy), 4096);
    check("full_done", 32'(done), 1);
    check("full_busy", 32'(busy), 0);
    check("full_count", 32'(pix_count), 4096);
    check("full_ready", 32'(pix_ready), 0);
    rd(19'd0, 3'd0, "rd_0");
    rd(19'd7, 3'd7, "rd_7");
    rd(19'd4095, 3'd7, "rd_4095");
    rd(19'd13, 3'd5, "rd_13");
    rd(19'd4096, 3'd0, "rd_4096");
    rd(19'h7FFFF, 3'd0, "rd_7ffff");
    pix_valid = 1'b1;
    repeat (4) step();
    pix_valid = 1'b0;
    check("done_valid_count", 32'(pix_count), 4096);

    // Restart from DONE, then gapped stream with junk on idle beats
    load_start = 1'b1; step(); load_start = 1'b0;
    check("restart_done", 32'(done), 0);
    check("restart_busy", 32'(busy), 1);
    check("restart_count", 32'(pix_count), 0);
    idx = 0; cyc = 0; v = 1'b0;
    while (idx < 4096 && cyc < 10000) begin
      v = ~v;
      pix_valid = v;
      pix_data = v ? 3'(idx % 8) : ~3'(idx % 8);
      step();
      if (v) idx++;
      cyc++;
    end
    pix_valid = 1'b0;
    check("bp_cycles", 32'(cyc), 8191);
    check("bp_done", 32'(done), 1);
    check("bp_count", 32'(pix_count), 4096);
    rd(19'd13, 3'd5, "bp_rd_13");
    rd(19'd4094, 3'd6, "bp_rd_4094");
    rd(19'd4095, 3'd7, "bp_rd_4095");

    // Abort after 100 pixels of pattern (i+2)%8
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      pix_data = 3'((i + 2) % 8);
      pix_valid = 1'b1;
      step();
    end
    pix_valid = 1'b0;
    check("pre_abort_count", 32'(pix_count), 100);
    load_abort = 1'b1; step(); load_abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_ready", 32'(pix_ready), 0);
    check("abort_count", 32'(pix_count), 100);
    rd(19'd99, 3'd5, "abort_rd_99_new");
    rd(19'd100, 3'd4, "abort_rd_100_old");

    // Start and abort together while loading
    load_start = 1'b1; step(); load_start = 1'b0;
    pix_valid = 1'b1; repeat (3) step(); pix_valid = 1'b0;
    load_start = 1'b1; load_abort = 1'b1; step();
    load_start = 1'b0; load_abort = 1'b0;
    check("coll_busy", 32'(busy), 0);
    check("coll_ready", 32'(pix_ready), 0);
    check("coll_count", 32'(pix_count), 3);

    // Restart during LOAD discards the same-cycle pixel
    load_start = 1'b1; step(); load_start = 1'b0;
    pix_valid = 1'b1; repeat (5) step();
    load_start = 1'b1; step(); load_start = 1'b0;
    pix_valid = 1'b0;
    check("reload_count", 32'(pix_count), 0);
    check("reload_busy", 32'(busy), 1);

    // Async reset mid-load, checked without a clock edge
    pix_valid = 1'b1; repeat (5) step(); pix_valid = 1'b0;
    check("pre_rst_count", 32'(pix_count), 5);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_ready", 32'(pix_ready), 0);
    check("arst_count", 32'(pix_count), 0);
    check("arst_done", 32'(done), 0);
    check("arst_sprite", 32'(sprite_out), 0);
    step();
    Reset_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
